bp_fe_btb_assoc: RTL
====================

# bp_fe_btb_assoc

Set-associative branch target buffer for the BlackParrot front end, generalising the direct-mapped BTB to `ways_p` ways per set with tree pseudo-LRU replacement.
- Sits in bp_fe_pc_gen beside the BHT. It is read with the fetch PC in stage IF1 and answers in IF2.
- It is written on redirect/commit feedback from the backend.
- It reports the hit way, so the front end can carry that way through branch metadata and write back into the same way.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `vaddr_width_p`, `btb_tag_width_p`, `btb_idx_width_p`, `fetch_sel_gp`.
- `ways_p`, 2: ways per set; power of two, 1..8.
- `way_width_lp`, `` `BSG_SAFE_CLOG2(ways_p) ``: local; width of a way index.
- `clk_i  in  1`: clock. One clock only.
- `reset_i  in  1`: reset. Synchronous, active-high.
- `init_done_o  out  1`: high once every set is cleared.
- `r_addr_i  in  vaddr_width_p`: fetch PC.
- `r_v_i  in  1`: read request.
- `tag_o  out  btb_tag_width_p`: tag for the registered read.
- `idx_o  out  btb_idx_width_p`: set index for the registered read.
- `way_o  out  way_width_lp`: on a hit, the hit way; on a miss, the PLRU victim way.
- `br_tgt_o  out  vaddr_width_p`: predicted target.
- `br_tgt_v_o  out  1`: hit.
- `br_tgt_jmp_o  out  1`: the hit entry is an unconditional jump.
- `w_v_i  in  1`: write request.
- `w_clr_i  in  1`: invalidate the selected entry instead of writing it.
- `w_jmp_i  in  1`: jump flag for the new entry.
- `w_tag_i  in  btb_tag_width_p`: write tag.
- `w_idx_i  in  btb_idx_width_p`: write set.
- `w_way_v_i  in  1`: write into `w_way_i`; when low, allocate the PLRU victim.
- `w_way_i  in  way_width_lp`: explicit write way.
- `w_tgt_i  in  vaddr_width_p`: write target.
- `w_force_i  in  1`: on a same-set collision, the write wins over the read.
- `w_yumi_o  out  1`: write accepted this cycle.

## Operation
- **Address split**
  - hash = `r_addr_i[1+:fetch_sel_gp]`.
  - idx = next `btb_idx_width_p` bits.
  - tag = next `btb_tag_width_p` bits XOR hash (zero-extended).
  - Writers supply tag and idx already hashed.
- **Entry format**: {v, jmp, tag, tgt}. One `bsg_mem_1r1w_sync` per way, `latch_last_read_p=1`.
- **Init FSM**
  - States are e_reset, e_clear, e_run.
  - e_reset always moves to e_clear.
  - In e_clear, a counter walks sets 0..2^idx−1, writing zero to all ways and zeroing the set's PLRU bits.
  - e_clear moves to e_run after the last set. e_run is terminal.
  - Reads and writes are ignored outside e_run. `w_yumi_o`=0 outside e_run.
- **Read hit**: a way hits when v=1 and stored tag == `tag_o`.
  - `br_tgt_v_o` = any way hits and the read was not suppressed.
  - If several ways hit, the lowest-numbered way wins. `way_o`, `br_tgt_o` and `br_tgt_jmp_o` come from that way.
  - On a miss, `br_tgt_jmp_o`=0 and `way_o` = the current PLRU victim of `idx_o`.
- **Write way**: `w_way_i` if `w_way_v_i`, else the PLRU victim of `w_idx_i`.
  - Write data is the new entry with v=1.
  - If `w_clr_i`=1, the data is all-zero.
- **Collision**: `r_v_i & w_v_i & (r_idx == w_idx_i)`.
  - If `w_force_i`=1, the read is suppressed: the registered hit reports 0 and the write proceeds.
  - Otherwise the write is dropped (`w_yumi_o`=0) and the read proceeds; the writer retries.
- **PLRU**: tree PLRU, ways_p−1 bits per set, held in flops. For ways_p=1 there is no state and the victim is 0.
  - An accepted non-clear write marks the written way MRU.
  - An accepted clear write marks the cleared way LRU.
  - A read hit marks the hit way MRU in the cycle `br_tgt_v_o` is high.
  - If a write and a read-hit update target the same set in the same cycle, the write update alone is applied.

## Timing
- Read latency is 1 cycle.
  - `tag_o`, `idx_o`, `way_o` and the suppress flag are registered when `r_v_i`=1. They hold otherwise, and the outputs stay stable.
- A write lands at the clock edge in the cycle `w_yumi_o`=1. `w_yumi_o` is combinational from the inputs and the FSM.
- A read of a set in the cycle after a write to that set returns the new data.
- Reset values:
  - `init_done_o`=0.
  - `br_tgt_v_o`=0 until the first read issued in e_run.
  - The `tag_o`/`idx_o`/`way_o` registers reset to 0.
  - The PLRU flops reset to 0.
- Reset asserted mid-clear or mid-run returns to e_reset and re-clears every set. In-flight reads report a miss.
- Init takes 2^btb_idx_width_p+1 cycles after reset deasserts.

## Structure
- Entry struct and PLRU width macros go in `bp_fe_defines.svh`: `` `declare_bp_fe_btb_entry_s ``, `` `bp_fe_btb_lru_width(ways_p) ``.
- Sub-module `bp_fe_btb_plru`:
  - Holds the per-set tree-PLRU flop array.
  - One victim read port, keyed by set.
  - Two update ports, read-hit and write, with write priority on the same set.
  - Built from `bsg_lru_pseudo_tree_decode` and `bsg_lru_pseudo_tree_encode`.

## Test plan
- **Init**: ways_p=2, idx=6. Drop reset, then read every set -> `init_done_o` rises at cycle 65, every read misses, and `way_o`=0.
- **Fill and replace**: write tags A, B, C to set 5 with `w_way_v_i`=0 and no reads between -> A goes to way 0, B to way 1, C replaces A in way 0. Reads then give: A misses; C hits with way_o=0; B hits with way_o=1.
- **Explicit way and clear**: write tgt 0x8000_0040 to way 1 of set 3, then clear way 1 of set 3 -> first read hits with the target; after the clear it misses and `way_o`=1.
- **Collision**: read and write set 7 in the same cycle.
  - With `w_force_i`=1: `w_yumi_o`=1, `br_tgt_v_o`=0, and the next read hits the new entry.
  - With `w_force_i`=0: `w_yumi_o`=0 and the read returns the old entry.
- **PLRU touch by read**: fill set 2 with ways 0 and 1, read-hit way 0, then allocate -> the allocation goes to way 1.
- **Reset mid-run**: assert reset for 1 cycle after filling -> `init_done_o`=0 immediately and all sets miss after re-init.

Source files
------------

// File: rtl/bp_fe_btb_pkg.sv
// Geometry, entry layout, init states and tree-PLRU helpers shared by the associative BTB.
package bp_fe_btb_pkg;
    localparam int vaddr_width_p   = 39;
    localparam int btb_tag_width_p = 10;
    localparam int btb_idx_width_p = 6;
    localparam int fetch_sel_gp    = 2;
    localparam int btb_sets_lp     = 1 << btb_idx_width_p;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_clear = 2'd1,
        e_run   = 2'd2
    } btb_init_state_e;

    typedef struct packed {
        logic                       v;
        logic                       jmp;
        logic [btb_tag_width_p-1:0] tag;
        logic [vaddr_width_p-1:0]   tgt;
    } btb_entry_s;

    function automatic int btb_lru_width(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    // Tree bits are heap-ordered; a 0 bit steers the victim into the lower-numbered half.
    function automatic logic [2:0] plru_victim(input logic [6:0] bits, input logic [1:0] levels);
        logic [2:0] node;
        logic [2:0] way;
        node = 3'd0;
        way  = 3'd0;
        for (int l = 0; l < 3; l++) begin
            if (l < int'(levels)) begin
                way  = {way[1:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return way;
    endfunction

    // mru=1 points every node on the way's path away from it; mru=0 points them at it.
    function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                              input logic [1:0] levels, input logic mru);
        logic [6:0] res;
        logic [2:0] node;
        logic       b;
        res  = bits;
        node = 3'd0;
        for (int l = 0; l < 3; l++) begin
            if (l < int'(levels)) begin
                b         = way[2'(int'(levels) - 1 - l)];
                res[node] = b ^ mru;
                node      = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/bp_fe_btb_assoc_plru.sv
// Per-set tree pseudo-LRU state with victim lookup, read-hit and write updates (write wins on a shared set).
module bp_fe_btb_assoc_plru
    import bp_fe_btb_pkg::*;
#(
    parameter int ways_p       = 2,
    parameter int way_width_lp = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clr_v_i,
    input  logic [btb_idx_width_p-1:0] clr_idx_i,
    input  logic [btb_idx_width_p-1:0] r_idx_i,
    output logic [way_width_lp-1:0]    r_victim_o,
    input  logic [btb_idx_width_p-1:0] w_idx_i,
    output logic [way_width_lp-1:0]    w_victim_o,
    input  logic                       hit_v_i,
    input  logic [btb_idx_width_p-1:0] hit_idx_i,
    input  logic [way_width_lp-1:0]    hit_way_i,
    input  logic                       w_v_i,
    input  logic                       w_mru_i,
    input  logic [way_width_lp-1:0]    w_way_i
);
    localparam int lru_width_lp = btb_lru_width(ways_p);
    localparam int levels_lp    = $clog2(ways_p);

    logic [lru_width_lp-1:0] lru_q [btb_sets_lp];

    assign r_victim_o = way_width_lp'(plru_victim(7'(lru_q[r_idx_i]), 2'(levels_lp)));
    assign w_victim_o = way_width_lp'(plru_victim(7'(lru_q[w_idx_i]), 2'(levels_lp)));

    // Tree state: init clear, then read-hit and write touches.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < btb_sets_lp; s++) begin
                lru_q[s] <= '0;
            end
        end else if (clr_v_i) begin
            lru_q[clr_idx_i] <= '0;
        end else begin
            if (hit_v_i && !(w_v_i && (w_idx_i == hit_idx_i))) begin
                lru_q[hit_idx_i] <= lru_width_lp'(plru_touch(7'(lru_q[hit_idx_i]), 3'(hit_way_i),
                                                             2'(levels_lp), 1'b1));
            end
            if (w_v_i) begin
                lru_q[w_idx_i] <= lru_width_lp'(plru_touch(7'(lru_q[w_idx_i]), 3'(w_way_i),
                                                           2'(levels_lp), w_mru_i));
            end
        end
    end
endmodule

// File: rtl/bp_fe_btb_assoc.sv
// Set-associative branch target buffer: IF1 read, IF2 answer, backend writes with PLRU allocation.
module bp_fe_btb_assoc
    import bp_fe_btb_pkg::*;
#(
    parameter  int ways_p       = 2,
    localparam int way_width_lp = (ways_p > 1) ? $clog2(ways_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,
    input  logic [vaddr_width_p-1:0]   r_addr_i,
    input  logic                       r_v_i,
    output logic [btb_tag_width_p-1:0] tag_o,
    output logic [btb_idx_width_p-1:0] idx_o,
    output logic [way_width_lp-1:0]    way_o,
    output logic [vaddr_width_p-1:0]   br_tgt_o,
    output logic                       br_tgt_v_o,
    output logic                       br_tgt_jmp_o,
    input  logic                       w_v_i,
    input  logic                       w_clr_i,
    input  logic                       w_jmp_i,
    input  logic [btb_tag_width_p-1:0] w_tag_i,
    input  logic [btb_idx_width_p-1:0] w_idx_i,
    input  logic                       w_way_v_i,
    input  logic [way_width_lp-1:0]    w_way_i,
    input  logic [vaddr_width_p-1:0]   w_tgt_i,
    input  logic                       w_force_i,
    output logic                       w_yumi_o
);
    localparam int addr_used_lp = fetch_sel_gp + btb_idx_width_p + btb_tag_width_p;

    btb_init_state_e            state_q, state_d;
    logic [btb_idx_width_p-1:0] clr_cnt_q, clr_cnt_d;
    logic                       run_s, clear_s;

    logic [fetch_sel_gp-1:0]    r_hash_s;
    logic [btb_idx_width_p-1:0] r_idx_s;
    logic [btb_tag_width_p-1:0] r_tag_s;
    logic                       r_acc_s, same_set_s, w_yumi_s, hit_s, any_hit_s;
    logic [way_width_lp-1:0]    r_victim_s, w_victim_s, w_way_s, hit_way_s;
    btb_entry_s                 w_entry_s;
    logic                       unused_addr_s;

    btb_entry_s                 mem_q   [ways_p][btb_sets_lp];
    btb_entry_s                 rdata_q [ways_p];
    logic [btb_tag_width_p-1:0] tag_q;
    logic [btb_idx_width_p-1:0] idx_q;
    logic [way_width_lp-1:0]    way_q;
    logic                       sup_q, rd_v_q, rd_new_q;

    assign r_hash_s      = r_addr_i[1 +: fetch_sel_gp];
    assign r_idx_s       = r_addr_i[1 + fetch_sel_gp +: btb_idx_width_p];
    assign r_tag_s       = r_addr_i[1 + fetch_sel_gp + btb_idx_width_p +: btb_tag_width_p]
                           ^ btb_tag_width_p'(r_hash_s);
    assign unused_addr_s = ^{r_addr_i[0], r_addr_i[vaddr_width_p-1:addr_used_lp+1]};

    assign run_s      = (state_q == e_run) && !reset_i;
    assign clear_s    = (state_q == e_clear);
    assign r_acc_s    = r_v_i && run_s;
    assign same_set_s = r_v_i && w_v_i && (r_idx_s == w_idx_i);
    // A forced write steals the set from the read; otherwise the writer must retry.
    assign w_yumi_s   = run_s && w_v_i && !(same_set_s && !w_force_i);
    assign w_way_s    = w_way_v_i ? w_way_i : w_victim_s;
    assign w_entry_s  = w_clr_i ? '0 : {1'b1, w_jmp_i, w_tag_i, w_tgt_i};

    // Init FSM state and clear counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_reset;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Init FSM next state: walk every set once, then run forever.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            e_reset: begin
                state_d   = e_clear;
                clr_cnt_d = '0;
            end
            e_clear: begin
                clr_cnt_d = clr_cnt_q + btb_idx_width_p'(1);
                state_d   = (clr_cnt_q == '1) ? e_run : e_clear;
            end
            e_run:   state_d = e_run;
            default: state_d = e_reset;
        endcase
    end

    // Entry storage per way; read data holds between reads.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < ways_p; w++) begin
            if (clear_s) begin
                mem_q[w][clr_cnt_q] <= '0;
            end else if (w_yumi_s && (w_way_s == way_width_lp'(w))) begin
                mem_q[w][w_idx_i] <= w_entry_s;
            end
            if (r_acc_s) begin
                rdata_q[w] <= mem_q[w][r_idx_s];
            end
        end
    end

    // IF1 -> IF2 read bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_q    <= '0;
            idx_q    <= '0;
            way_q    <= '0;
            sup_q    <= 1'b0;
            rd_v_q   <= 1'b0;
            rd_new_q <= 1'b0;
        end else begin
            rd_new_q <= r_acc_s;
            if (r_acc_s) begin
                tag_q  <= r_tag_s;
                idx_q  <= r_idx_s;
                way_q  <= r_victim_s;
                sup_q  <= same_set_s && w_force_i;
                rd_v_q <= 1'b1;
            end
        end
    end

    // Hit detection; scanning downwards leaves the lowest matching way selected.
    always_comb begin
        any_hit_s = 1'b0;
        hit_way_s = '0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            hit_way_s = (rdata_q[w].v && (rdata_q[w].tag == tag_q)) ? way_width_lp'(w) : hit_way_s;
            any_hit_s = any_hit_s || (rdata_q[w].v && (rdata_q[w].tag == tag_q));
        end
    end

    assign hit_s        = rd_v_q && !sup_q && any_hit_s;
    assign init_done_o  = (state_q == e_run);
    assign tag_o        = tag_q;
    assign idx_o        = idx_q;
    assign way_o        = hit_s ? hit_way_s : way_q;
    assign br_tgt_v_o   = hit_s;
    assign br_tgt_jmp_o = hit_s && rdata_q[hit_way_s].jmp;
    assign br_tgt_o     = rdata_q[hit_way_s].tgt;
    assign w_yumi_o     = w_yumi_s;

    bp_fe_btb_assoc_plru #(
        .ways_p       (ways_p),
        .way_width_lp (way_width_lp)
    ) plru (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_v_i    (clear_s),
        .clr_idx_i  (clr_cnt_q),
        .r_idx_i    (r_idx_s),
        .r_victim_o (r_victim_s),
        .w_idx_i    (w_idx_i),
        .w_victim_o (w_victim_s),
        .hit_v_i    (hit_s && rd_new_q),
        .hit_idx_i  (idx_q),
        .hit_way_i  (hit_way_s),
        .w_v_i      (w_yumi_s),
        .w_mru_i    (!w_clr_i),
        .w_way_i    (w_way_s)
    );
endmodule
